// File: rtl/rect_label_engine_pkg.sv
// Shared types and default constants for the streaming rectangle labeller.
package rect_label_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_MERGE,
    S_FLUSH,
    S_DONE
  } state_t;

  // Default grid geometry and grid-to-screen mapping
  localparam int DEF_GRID_W      = 40;
  localparam int DEF_GRID_H      = 30;
  localparam int DEF_CW          = 8;
  localparam int DEF_N_LBL       = 16;
  localparam int DEF_LW          = 4;
  localparam int DEF_PW          = 12;
  localparam int DEF_SCALE_SHIFT = 2;
  localparam int DEF_X_OFF       = 28;
  localparam int DEF_Y_OFF       = 0;
  localparam int DEF_OW          = 10;

endpackage

// File: rtl/rect_label_engine_free_stack.sv
// LIFO of unused label numbers; init/reset loads 1..DEPTH with 1 on top.
module label_free_stack #(
  parameter int N_LBL = 16,
  parameter int LW    = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          init,
  input  logic          push,
  input  logic          pop,
  input  logic [LW-1:0] din,
  output logic [LW-1:0] dout,
  output logic          empty
);

  localparam int DEPTH = N_LBL - 1;

  logic [LW-1:0] mem [DEPTH];
  logic [LW-1:0] sp;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sp <= LW'(DEPTH);
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= LW'(DEPTH - i);
    end else if (init) begin
      sp <= LW'(DEPTH);
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= LW'(DEPTH - i);
    end else if (push) begin
      mem[sp] <= din;
      sp      <= sp + 1'b1;
    end else if (pop) begin
      sp <= sp - 1'b1;
    end
  end

  assign empty = (sp == '0);
  assign dout  = empty ? '0 : mem[sp - 1'b1];

endmodule

// File: rtl/rect_label_engine.sv
// Streaming connected-component labeller: raster pixels in, one filtered
// screen-space bounding box per surviving blob out.
module rect_label_engine
  import rect_label_engine_pkg::*;
#(
  parameter int GRID_W      = DEF_GRID_W,
  parameter int GRID_H      = DEF_GRID_H,
  parameter int CW          = DEF_CW,
  parameter int N_LBL       = DEF_N_LBL,
  parameter int LW          = DEF_LW,
  parameter int PW          = DEF_PW,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int X_OFF       = DEF_X_OFF,
  parameter int Y_OFF       = DEF_Y_OFF,
  parameter int OW          = DEF_OW
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          i_start,
  input  logic          i_valid,
  input  logic          i_pix,
  output logic          o_ready,
  input  logic [CW-1:0] i_min_w,
  input  logic [CW-1:0] i_min_h,
  input  logic [PW-1:0] i_min_cnt,
  output logic          o_rect_valid,
  output logic [OW-1:0] o_rect_x1,
  output logic [OW-1:0] o_rect_y1,
  output logic [OW-1:0] o_rect_x2,
  output logic [OW-1:0] o_rect_y2,
  output logic [PW-1:0] o_rect_cnt,
  output logic [LW-1:0] o_rect_num,
  output logic          o_done,
  output logic          o_overflow,
  output logic          o_busy
);

  typedef struct packed {
    logic          v;
    logic [PW-1:0] cnt;
    logic [CW-1:0] y2;
    logic [CW-1:0] x2;
    logic [CW-1:0] y1;
    logic [CW-1:0] x1;
  } entry_t;

  localparam logic [CW-1:0] X_LAST = CW'(GRID_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(GRID_H - 1);
  localparam logic [LW-1:0] K_LAST = LW'(N_LBL - 1);

  state_t        state, state_nx;
  entry_t        tbl [N_LBL];
  logic [LW-1:0] linebuf [GRID_W];
  logic [CW-1:0] x, y;
  logic [LW-1:0] k, mrg_old, mrg_new;
  logic          scan_end;

  logic          accept, last_px, is_none, is_both;
  logic [LW-1:0] up, left, hit;
  logic          st_push, st_pop, st_empty;
  logic [LW-1:0] st_dout;
  entry_t        e_new, e_k;
  logic [PW:0]   cnt_sum;
  logic [CW:0]   box_w, box_h;
  logic          keep;

  always_comb begin
    up      = linebuf[GRID_W-1];
    left    = (x == '0) ? '0 : linebuf[0];
    accept  = (state == S_SCAN) && i_valid && !i_start;
    last_px = (x == X_LAST) && (y == Y_LAST);
    is_none = i_pix && (up == '0) && (left == '0);
    is_both = i_pix && (up != '0) && (left != '0) && (up != left);
    hit     = (up != '0) ? up : left;
    st_pop  = accept && is_none && !st_empty;
    st_push = accept && is_both;
  end

  // Updated entry for the label the current pixel lands in
  always_comb begin
    e_new   = tbl[hit];
    cnt_sum = {1'b0, tbl[hit].cnt} + (PW+1)'(1);
    if (is_both) begin
      if (tbl[left].x1 < e_new.x1) e_new.x1 = tbl[left].x1;
      if (tbl[left].y1 < e_new.y1) e_new.y1 = tbl[left].y1;
      if (tbl[left].x2 > e_new.x2) e_new.x2 = tbl[left].x2;
      if (tbl[left].y2 > e_new.y2) e_new.y2 = tbl[left].y2;
      cnt_sum = cnt_sum + {1'b0, tbl[left].cnt};
    end
    if (x < e_new.x1) e_new.x1 = x;
    if (y < e_new.y1) e_new.y1 = y;
    if (x > e_new.x2) e_new.x2 = x;
    if (y > e_new.y2) e_new.y2 = y;
    e_new.cnt = cnt_sum[PW] ? '1 : cnt_sum[PW-1:0];
    e_new.v   = 1'b1;
    if (is_none) e_new = '{v: 1'b1, cnt: PW'(1), y2: y, x2: x, y1: y, x1: x};
  end

  always_comb begin
    e_k   = tbl[k];
    box_w = {1'b0, e_k.x2} - {1'b0, e_k.x1} + (CW+1)'(1);
    box_h = {1'b0, e_k.y2} - {1'b0, e_k.y1} + (CW+1)'(1);
    keep  = e_k.v && (box_w >= {1'b0, i_min_w}) && (box_h >= {1'b0, i_min_h})
            && (e_k.cnt >= i_min_cnt);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = S_IDLE;
      S_CLEAR: state_nx = S_SCAN;
      S_SCAN:  if (accept) begin
                 if (is_both)      state_nx = S_MERGE;
                 else if (last_px) state_nx = S_FLUSH;
               end
      S_MERGE: state_nx = scan_end ? S_FLUSH : S_SCAN;
      S_FLUSH: if (k == K_LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (i_start) state_nx = S_CLEAR;
    o_ready = (state == S_SCAN);
    o_busy  = (state != S_IDLE);
  end

  label_free_stack #(.N_LBL(N_LBL), .LW(LW)) u_free_stack (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .init     (state == S_CLEAR),
    .push     (st_push),
    .pop      (st_pop),
    .din      (left),
    .dout     (st_dout),
    .empty    (st_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < N_LBL; i++)  tbl[i] <= '0;
      for (int unsigned i = 0; i < GRID_W; i++) linebuf[i] <= '0;
      x            <= '0;
      y            <= '0;
      k            <= LW'(1);
      mrg_old      <= '0;
      mrg_new      <= '0;
      scan_end     <= 1'b0;
      o_rect_valid <= 1'b0;
      o_rect_x1    <= '0;
      o_rect_y1    <= '0;
      o_rect_x2    <= '0;
      o_rect_y2    <= '0;
      o_rect_cnt   <= '0;
      o_rect_num   <= '0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_rect_valid <= 1'b0;
      o_done       <= (state == S_DONE);
      case (state)
        S_CLEAR: begin
          for (int unsigned i = 0; i < N_LBL; i++)  tbl[i] <= '0;
          for (int unsigned i = 0; i < GRID_W; i++) linebuf[i] <= '0;
          x          <= '0;
          y          <= '0;
          k          <= LW'(1);
          scan_end   <= 1'b0;
          o_overflow <= 1'b0;
          o_rect_num <= '0;
        end
        S_SCAN: if (accept) begin
          for (int unsigned i = GRID_W - 1; i > 0; i--) linebuf[i] <= linebuf[i-1];
          if (!i_pix) begin
            linebuf[0] <= '0;
          end else if (is_none) begin
            if (st_empty) begin
              o_overflow <= 1'b1;
              linebuf[0] <= '0;
            end else begin
              tbl[st_dout] <= e_new;
              linebuf[0]   <= st_dout;
            end
          end else begin
            tbl[hit]   <= e_new;
            linebuf[0] <= hit;
            if (is_both) begin
              mrg_old <= left;
              mrg_new <= up;
            end
          end
          if (x == X_LAST) begin
            x <= '0;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
          if (last_px) scan_end <= 1'b1;
        end
        // Retired label may still sit anywhere in the row window
        S_MERGE: begin
          for (int unsigned i = 0; i < GRID_W; i++)
            if (linebuf[i] == mrg_old) linebuf[i] <= mrg_new;
          tbl[mrg_old] <= '0;
        end
        S_FLUSH: if (!i_start) begin
          if (keep) begin
            o_rect_valid <= 1'b1;
            o_rect_x1    <= (OW'(e_k.x1) << SCALE_SHIFT) + OW'(X_OFF);
            o_rect_y1    <= (OW'(e_k.y1) << SCALE_SHIFT) + OW'(Y_OFF);
            o_rect_x2    <= ((OW'(e_k.x2) + OW'(1)) << SCALE_SHIFT) + OW'(X_OFF);
            o_rect_y2    <= ((OW'(e_k.y2) + OW'(1)) << SCALE_SHIFT) + OW'(Y_OFF);
            o_rect_cnt   <= e_k.cnt;
            o_rect_num   <= o_rect_num + 1'b1;
          end
          k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_label_engine.sv
// Table-driven frame tests with a flood-fill reference model feeding a rect scoreboard.
module tb_rect_label_engine;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       i_start = 1'b0, i_valid = 1'b0, i_pix = 1'b0;
  logic [7:0] i_min_w = 8'd1, i_min_h = 8'd1;
  logic [11:0] i_min_cnt = 12'd1;
  logic       o_ready, o_rect_valid, o_done, o_overflow, o_busy;
  logic [9:0] o_rect_x1, o_rect_y1, o_rect_x2, o_rect_y2;
  logic [11:0] o_rect_cnt;
  logic [2:0] o_rect_num;

  always #5 sys_clk = ~sys_clk;

  rect_label_engine #(
    .GRID_W(8), .GRID_H(6), .CW(8), .N_LBL(8), .LW(3), .PW(12),
    .SCALE_SHIFT(2), .X_OFF(28), .Y_OFF(0), .OW(10)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_start(i_start),
    .i_valid(i_valid), .i_pix(i_pix), .o_ready(o_ready),
    .i_min_w(i_min_w), .i_min_h(i_min_h), .i_min_cnt(i_min_cnt),
    .o_rect_valid(o_rect_valid), .o_rect_x1(o_rect_x1), .o_rect_y1(o_rect_y1),
    .o_rect_x2(o_rect_x2), .o_rect_y2(o_rect_y2), .o_rect_cnt(o_rect_cnt),
    .o_rect_num(o_rect_num), .o_done(o_done), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  typedef struct packed {
    logic [9:0]  x1, y1, x2, y2;
    logic [11:0] cnt;
  } rect_t;

  typedef struct packed {
    logic [47:0] pat;
    int          mw, mh, mc;
    int          num, ovf, stalls, gap;
  } tc_t;

  rect_t exp_q[$];
  tc_t   tcs[8];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, rect_cnt = 0, done_num = 0, done_ovf = 0;
  int done_cyc = 0, last_rect_cyc = 0;

  always @(negedge sys_clk) begin
    rect_t got, e;
    cyc++;
    if (o_done) begin
      done_cnt++;
      done_num = int'(o_rect_num);
      done_ovf = int'(o_overflow);
      done_cyc = cyc;
    end
    if (o_rect_valid) begin
      got = {o_rect_x1, o_rect_y1, o_rect_x2, o_rect_y2, o_rect_cnt};
      rect_cnt++;
      last_rect_cyc = cyc;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rect_extra: got (%0d,%0d,%0d,%0d) cnt %0d, none expected",
                 got.x1, got.y1, got.x2, got.y2, got.cnt);
      end else begin
        e = exp_q.pop_front();
        if (got != e) begin
          n_fail++;
          $display("FAIL rect: got (%0d,%0d,%0d,%0d) cnt %0d expected (%0d,%0d,%0d,%0d) cnt %0d",
                   got.x1, got.y1, got.x2, got.y2, got.cnt, e.x1, e.y1, e.x2, e.y2, e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [47:0] px(input int x, input int y);
    logic [47:0] v;
    v = '0;
    v[y*8+x] = 1'b1;
    return v;
  endfunction

  // 4-connected components by min-index propagation; emission follows raster order of each blob's first pixel
  task automatic build_expect(input logic [47:0] pat, input int mw, input int mh, input int mc);
    int lab[48];
    int ncomp, minx, miny, maxx, maxy, cnt;
    rect_t r;
    for (int i = 0; i < 48; i++) lab[i] = pat[i] ? i + 1 : 0;
    for (int it = 0; it < 48; it++)
      for (int i = 0; i < 48; i++)
        if (lab[i] != 0) begin
          if (i % 8 > 0 && lab[i-1] != 0 && lab[i-1] < lab[i]) lab[i] = lab[i-1];
          if (i % 8 < 7 && lab[i+1] != 0 && lab[i+1] < lab[i]) lab[i] = lab[i+1];
          if (i >= 8 && lab[i-8] != 0 && lab[i-8] < lab[i]) lab[i] = lab[i-8];
          if (i < 40 && lab[i+8] != 0 && lab[i+8] < lab[i]) lab[i] = lab[i+8];
        end
    ncomp = 0;
    for (int h = 0; h < 48; h++) begin
      if (lab[h] != h + 1) continue;
      ncomp++;
      if (ncomp > 7) continue;
      minx = 99; miny = 99; maxx = -1; maxy = -1; cnt = 0;
      for (int i = 0; i < 48; i++)
        if (lab[i] == h + 1) begin
          cnt++;
          if (i % 8 < minx) minx = i % 8;
          if (i % 8 > maxx) maxx = i % 8;
          if (i / 8 < miny) miny = i / 8;
          if (i / 8 > maxy) maxy = i / 8;
        end
      if (maxx - minx + 1 >= mw && maxy - miny + 1 >= mh && cnt >= mc) begin
        r.x1 = 10'(minx * 4 + 28);
        r.y1 = 10'(miny * 4);
        r.x2 = 10'((maxx + 1) * 4 + 28);
        r.y2 = 10'((maxy + 1) * 4);
        r.cnt = 12'(cnt);
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic run_frame(input logic [47:0] pat, input int abort_at,
                           output int stalls, output int ovf_pre);
    int idx, guard;
    logic rdy;
    idx = 0; guard = 0; stalls = 0; ovf_pre = 0;
    @(posedge sys_clk); #1 i_start = 1'b1;
    @(posedge sys_clk); #1 i_start = 1'b0;
    i_valid = 1'b1;
    i_pix   = pat[0];
    while (idx < 48 && guard < 400) begin
      guard++;
      if (idx == abort_at) i_start = 1'b1;
      @(negedge sys_clk);
      rdy = o_ready;
      if (idx == abort_at) ovf_pre = int'(o_overflow);
      if (!rdy && idx > 0) stalls++;
      @(posedge sys_clk); #1;
      if (idx == abort_at) begin
        i_start = 1'b0;
        i_valid = 1'b0;
        return;
      end
      if (rdy) idx++;
      if (idx < 48) i_pix = pat[idx];
    end
    i_valid = 1'b0;
    if (idx < 48) chk("frame_timeout_pixels_sent", idx, 48);
  endtask

  task automatic run_case(input int t);
    tc_t c;
    int d0, r0, stalls, ovf_pre, n;
    c = tcs[t];
    i_min_w = 8'(c.mw); i_min_h = 8'(c.mh); i_min_cnt = 12'(c.mc);
    d0 = done_cnt; r0 = rect_cnt;
    build_expect(c.pat, c.mw, c.mh, c.mc);
    run_frame(c.pat, -1, stalls, ovf_pre);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (4) @(negedge sys_clk);
    chk($sformatf("c%0d_done_pulses", t), done_cnt - d0, 1);
    chk($sformatf("c%0d_rects_seen", t), rect_cnt - r0, c.num);
    chk($sformatf("c%0d_rect_num", t), done_num, c.num);
    chk($sformatf("c%0d_overflow", t), done_ovf, c.ovf);
    chk($sformatf("c%0d_ready_stalls", t), stalls, c.stalls);
    chk($sformatf("c%0d_rects_missing", t), exp_q.size(), 0);
    chk($sformatf("c%0d_busy_after", t), int'(o_busy), 0);
    if (c.gap >= 0) chk($sformatf("c%0d_done_gap", t), done_cyc - last_rect_cyc, c.gap);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [47:0] blk, u, eight, bars;
    int stalls, ovf_pre, d0;

    blk = px(1,1) | px(2,1) | px(1,2) | px(2,2);
    u = px(2,3) | px(3,3);
    for (int yy = 0; yy < 4; yy++) u = u | px(1,yy) | px(4,yy);
    eight = px(0,0) | px(2,0) | px(4,0) | px(6,0) | px(0,2) | px(2,2) | px(4,2) | px(6,2);
    bars = 48'hFF | px(7,2) | px(7,3) | px(7,4) | px(7,5);

    //        pattern    mw mh mc num ovf stall gap
    tcs[0] = '{px(3,2),  1, 1, 1, 1,  0,  0,    7};
    tcs[1] = '{blk,      1, 1, 1, 1,  0,  0,   -1};
    tcs[2] = '{u,        1, 1, 1, 1,  0,  1,   -1};
    tcs[3] = '{eight,    1, 1, 1, 7,  1,  0,    1};
    tcs[4] = '{blk,      3, 1, 1, 0,  0,  0,   -1};
    tcs[5] = '{blk,      2, 2, 1, 1,  0,  0,   -1};
    tcs[6] = '{bars,     1, 1, 5, 1,  0,  0,   -1};
    tcs[7] = '{bars,     1, 1, 4, 2,  0,  0,   -1};

    #12;
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_rect_valid", int'(o_rect_valid), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_overflow", int'(o_overflow), 0);
    chk("rst_rect_num", int'(o_rect_num), 0);
    chk("rst_rect_coords", int'({o_rect_x1, o_rect_y1, o_rect_x2}), 0);
    @(posedge sys_clk); #2 sys_rst_n = 1'b1;

    for (int t = 0; t < 8; t++) run_case(t);

    // Abort mid-row 3 after the overflow has already been flagged
    i_min_w = 8'd1; i_min_h = 8'd1; i_min_cnt = 12'd1;
    d0 = done_cnt;
    run_frame(eight, 27, stalls, ovf_pre);
    chk("abort_ovf_before", ovf_pre, 1);
    repeat (40) @(negedge sys_clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_ovf_cleared", int'(o_overflow), 0);
    chk("abort_num_cleared", int'(o_rect_num), 0);
    chk("abort_busy_scan", int'(o_busy), 1);

    // Asynchronous reset while waiting for pixels
    @(posedge sys_clk); #3 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_ready", int'(o_ready), 0);
    @(posedge sys_clk); #2 sys_rst_n = 1'b1;

    run_case(0);
    run_case(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
